// File: rtl/coeff_update_ctrl.sv
// Coefficient store with a load/update pass controller.
// A pass (LOAD or UPDATE) writes N_COEFF values in ascending index order.
// Each value is accepted on in_valid while the pass is active. The datapath
// reads the coefficients combinationally through rd_addr.
module coeff_update_ctrl #(
  parameter int N_COEFF = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  input  logic              update_start,
  input  logic              in_valid,
  input  logic [15:0]       input_k,
  input  logic [15:0]       update_k,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              in_ready,
  output logic              update_coeff,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       k,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Storage covers the whole address space so every rd_addr value is a
  // legal index; entries at N_COEFF and above are never written.
  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_COEFF - 1);
  localparam logic [ADDR_W:0]   N_LIMIT = (ADDR_W + 1)'(N_COEFF);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] w_wr_addr_next;
  logic              w_accept;
  logic [15:0]       r_coeff [DEPTH];
  logic [DEPTH-1:0]  w_we;

  // State and write-pointer register; reset returns to IDLE at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_wr_addr <= w_wr_addr_next;
    end
  end

  // Next-state, pointer advance and status outputs.
  always_comb begin
    w_state_next   = r_state;
    w_wr_addr_next = r_wr_addr;
    w_accept       = 1'b0;
    in_ready       = 1'b0;
    update_coeff   = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (r_state)
      S_IDLE: begin
        // init_start wins when both requests arrive together.
        if (init_start) begin
          w_state_next   = S_LOAD;
          w_wr_addr_next = '0;
        end else if (update_start) begin
          w_state_next   = S_UPDATE;
          w_wr_addr_next = '0;
        end
      end
      S_LOAD, S_UPDATE: begin
        in_ready     = 1'b1;
        busy         = 1'b1;
        update_coeff = (r_state == S_UPDATE);
        w_accept     = in_valid;
        if (in_valid) begin
          // The pointer parks on the last index instead of wrapping.
          if (r_wr_addr == LAST) begin
            w_state_next = S_DONE;
          end else begin
            w_wr_addr_next = r_wr_addr + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Reset masks all handshakes and status so nothing is accepted or
    // reported while it is asserted, whatever state the FSM is in.
    if (rst) begin
      w_accept     = 1'b0;
      in_ready     = 1'b0;
      update_coeff = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
    end
  end

  assign wr_addr = r_wr_addr;

  // Write data selection: the update value during UPDATE, the initial value otherwise.
  always_comb begin
    k = update_coeff ? update_k : input_k;
  end

  // One write enable per storage entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_accept && (r_wr_addr == ADDR_W'(gi));
    end
  endgenerate

  // Coefficient registers: cleared by reset, loaded bit-exact from k on accept.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_coeff[i] <= '0;
      end else if (w_we[i]) begin
        r_coeff[i] <= k;
      end
    end
  end

  // Combinational read; a same-cycle write shows up only after the edge,
  // and indices past the stored range read as zero.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < N_LIMIT) begin
      rd_data = r_coeff[rd_addr];
    end
  end

endmodule

// File: tb/tb_coeff_update_ctrl.sv
// Scoreboard bench for coeff_update_ctrl (N_COEFF=8, ADDR_W=4 so that
// out-of-range read indices can be exercised).
module tb_coeff_update_ctrl;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_start = 1'b0;
  logic          update_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   input_k = '0;
  logic [15:0]   update_k = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          in_ready;
  logic          update_coeff;
  logic [AW-1:0] wr_addr;
  logic [15:0]   k;
  logic [15:0]   rd_data;
  logic          busy;
  logic          done;

  coeff_update_ctrl #(.N_COEFF(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .update_start(update_start),
    .in_valid(in_valid), .input_k(input_k), .update_k(update_k), .rd_addr(rd_addr),
    .in_ready(in_ready), .update_coeff(update_coeff), .wr_addr(wr_addr), .k(k),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          in_ready;
    logic          update_coeff;
    logic          busy;
    logic          done;
    logic [AW-1:0] wr_addr;
    logic [15:0]   k;
    logic [15:0]   rd_data;
    bit            full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  // Reference model: contents array plus pass bookkeeping.
  logic [15:0] m_mem [N];
  bit          m_known = 0;
  bit          m_active = 0;
  bit          m_upd = 0;
  bit          m_done = 0;
  int          m_idx = 0;
  int          m_done_exp = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  // One clock of stimulus: drive after the edge, push what the DUT should
  // show during this cycle, then advance the model across the next edge.
  task automatic drive(input logic r, input logic is, input logic us, input logic v,
                       input logic [15:0] ik, input logic [15:0] uk, input logic [AW-1:0] ra);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; init_start = is; update_start = us; in_valid = v;
    input_k = ik; update_k = uk; rd_addr = ra;
    if (r) begin
      e.in_ready = 0; e.update_coeff = 0; e.busy = 0; e.done = 0;
    end else begin
      e.in_ready     = m_active;
      e.busy         = m_active;
      e.update_coeff = m_active && m_upd;
      e.done         = m_done;
    end
    e.k       = e.update_coeff ? uk : ik;
    e.wr_addr = AW'(m_idx);
    e.rd_data = (int'(ra) < N) ? m_mem[int'(ra)] : 16'h0000;
    e.full    = m_known;
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_active = 0; m_done = 0; m_idx = 0; m_known = 1;
    end else if (m_active) begin
      if (v) begin
        m_mem[m_idx] = e.k;
        if (m_idx == N - 1) begin
          m_active = 0; m_done = 1; m_done_exp++;
        end else begin
          m_idx++;
        end
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (is) begin
      m_active = 1; m_upd = 0; m_idx = 0;
    end else if (us) begin
      m_active = 1; m_upd = 1; m_idx = 0;
    end
  endtask

  // Monitor: mid-cycle, compare the DUT against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("in_ready", {15'd0, in_ready}, {15'd0, e.in_ready});
      chk("update_coeff", {15'd0, update_coeff}, {15'd0, e.update_coeff});
      chk("busy", {15'd0, busy}, {15'd0, e.busy});
      chk("done", {15'd0, done}, {15'd0, e.done});
      chk("k", k, e.k);
      if (e.full) begin
        chk("wr_addr", {12'd0, wr_addr}, {12'd0, e.wr_addr});
        chk("rd_data", rd_data, e.rd_data);
      end
      if (in_valid && in_ready)
        $display("ACC addr=%0d k=%h upd=%0d", wr_addr, k, update_coeff);
    end
    if (done === 1'b1) done_seen++;
  end

  initial begin
    // Reset with junk on the other inputs.
    drive(1, 1, 1, 1, 16'h1111, 16'h2222, 4'd0);
    drive(1, 0, 1, 1, 16'h3333, 16'h4444, 4'd1);
    // Valid held high in IDLE: no writes, no ready.
    drive(0, 0, 0, 1, 16'h5555, 16'h6666, 4'd0);
    drive(0, 0, 0, 1, 16'h5555, 16'h6666, 4'd1);

    // Initial load of 0x0400..0x2000, then a DONE cycle with valid high.
    drive(0, 1, 0, 0, 16'h0, 16'h0, 4'd0);
    for (int i = 0; i < N; i++)
      drive(0, 0, 0, 1, 16'(16'h0400 * (i + 1)), 16'hBEEF, 4'(i));
    drive(0, 0, 0, 1, 16'h7777, 16'h8888, 4'd3);
    drive(0, 0, 0, 1, 16'h7777, 16'h8888, 4'd3);

    // Update pass with stalls on pass cycles 2 and 5.
    drive(0, 0, 1, 0, 16'h0, 16'h0, 4'd0);
    for (int c = 1; c <= N + 2; c++)
      drive(0, 0, 0, (c != 2 && c != 5), 16'h1234, 16'hFC00, 4'(c % N));
    for (int i = 0; i < N; i++) drive(0, 0, 0, 0, 16'h0, 16'h0, 4'(i));

    // Both starts together: LOAD wins; later update_start ignored.
    // Index 2 gets 0x7FFF while it is being read.
    drive(0, 1, 1, 0, 16'h0, 16'h0, 4'd2);
    for (int i = 0; i < N; i++)
      drive(0, 0, 1, 1, (i == 2) ? 16'h7FFF : 16'(i), 16'hAAAA, 4'd2);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 4'd2);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 4'd8);
    drive(0, 0, 0, 0, 16'h0, 16'h0, 4'd15);

    // Reset in the middle of an update pass.
    drive(0, 0, 1, 0, 16'h0, 16'h0, 4'd0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 16'h0, 16'h5A5A, 4'(i));
    drive(1, 1, 1, 1, 16'h0, 16'h5A5A, 4'd0);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 16'h0, 16'h0, 4'(i));

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7),
            16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    end
    drive(0, 0, 0, 0, 16'h0, 16'h0, 4'd0);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    chk("done_pulses", 16'(done_seen), 16'(m_done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_update_ctrl.md
COEFF_UPDATE_CTRL -- requirements
Module: coeff_update_ctrl

Interface
REQ-001 SHALL have parameter: N_COEFF, 8, number of stored coefficients (2..256).
REQ-002 SHALL have parameter: ADDR_W, 3, coefficient index width, with 2**ADDR_W >= N_COEFF.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: init_start  input  1  request a full initial load pass.
REQ-006 SHALL have port: update_start  input  1  request a full coefficient update pass.
REQ-007 SHALL have port: in_valid  input  1  a value is present on input_k (LOAD) or update_k (UPDATE).
REQ-008 SHALL have port: input_k  input  16  signed Q6.10 initial coefficient.
REQ-009 SHALL have port: update_k  input  16  signed Q6.10 updated coefficient.
REQ-010 SHALL have port: rd_addr  input  ADDR_W  read index for the datapath.
REQ-011 SHALL have port: in_ready  output  1  block accepts a value this cycle.
REQ-012 SHALL have port: update_coeff  output  1  high while in UPDATE; selects update_k over input_k.
REQ-013 SHALL have port: wr_addr  output  ADDR_W  index written on the next accepted value.
REQ-014 SHALL have port: k  output  16  signed selected write value: update_k if update_coeff, else input_k.
REQ-015 SHALL have port: rd_data  output  16  signed coefficient at rd_addr, combinational read.
REQ-016 SHALL have port: busy  output  1  high in LOAD or UPDATE.
REQ-017 SHALL have port: done  output  1  one-cycle pulse after the last write of a pass.

Function
REQ-018 SHALL implement states IDLE, LOAD, UPDATE, DONE.
REQ-019 SHALL go IDLE->LOAD on init_start and IDLE->UPDATE on update_start (only update_start high), with wr_addr cleared to 0 on the transition.
REQ-020 SHALL give init_start priority when both starts are high in the same IDLE cycle.
REQ-021 SHALL ignore both starts outside IDLE (no restart, no abort).
REQ-022 SHALL drive in_ready = 1 only in LOAD and UPDATE.
REQ-023 SHALL accept a value on a cycle with in_valid && in_ready and write k into coeff[wr_addr] at that edge.
REQ-024 SHALL increment wr_addr by 1 per accepted value, with no increment when in_valid is low (stall allowed on any cycle).
REQ-025 SHALL, on acceptance at wr_addr == N_COEFF-1, move to DONE and hold wr_addr at N_COEFF-1, with no wrap.
REQ-026 SHALL spend exactly one cycle in DONE, assert done=1 there, then return to IDLE.
REQ-027 SHALL drive update_coeff = 1 exactly while in UPDATE, 0 in all other states.
REQ-028 SHALL generate k combinationally from update_coeff, input_k and update_k every cycle.
REQ-029 SHALL store k bit-exact with no arithmetic, rounding or saturation.
REQ-030 SHALL, when rd_addr equals the address being written in that cycle, make rd_data return the old value and the new value from the next cycle.
REQ-031 SHALL make rd_data return 0 for rd_addr >= N_COEFF.
REQ-032 SHALL take a full pass of N_COEFF accepted values with in_valid held high: N_COEFF cycles in LOAD/UPDATE plus 1 DONE cycle.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set the state to IDLE, wr_addr=0 and all coefficients to 0.
REQ-034 SHALL hold in_ready=0, update_coeff=0, busy=0 and done=0 while rst is high and in the first cycle after it is released.
REQ-035 SHALL, on rst during LOAD or UPDATE, abort the pass without a done pulse and perform no write at that edge.
REQ-036 SHALL give rst priority over start inputs and in_valid in the same cycle.

Verification
REQ-037 SHALL be verified by: init_start, then in_valid=1 with input_k=0x0400,0x0800..0x2000 (N=8) -> 8 writes, wr_addr 0..7, done at cycle 9, rd_data[3]=0x1000.
REQ-038 SHALL be verified by: update_start after a load, update_k=0xFC00 on every cycle, in_valid low on cycles 2 and 5 -> update_coeff=1 for 10 cycles, all coefficients 0xFC00, one done pulse.
REQ-039 SHALL be verified by: init_start and update_start high in the same cycle -> LOAD entered, update_coeff stays 0; update_start during LOAD ignored.
REQ-040 SHALL be verified by: rst asserted after 4 UPDATE writes -> no done, rd_data=0 for all indices, busy=0 for the next cycle.
REQ-041 SHALL be verified by: rd_addr=2 while writing index 2 with 0x7FFF -> rd_data old value that cycle, 0x7FFF next cycle; rd_addr=8 -> 0.
REQ-042 SHALL be verified by: in_valid held high in IDLE and DONE -> no writes, in_ready=0.
